// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer.
//
// Contents:
//   XLEN, ILEN, INSTR_BYTES : address width, instruction width, bytes per instruction
//   fetch_state_t           : sequencer FSM states (IDLE, REQ, WAIT, HOLD)
//   align_target()          : clears the sub-instruction offset bits of a redirect target
//   next_seq_pc()           : sequential successor address (wraps modulo 2^XLEN)
package fetch_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned ILEN        = 32;
    localparam int unsigned INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
    } fetch_state_t;

    // Masking keeps every target bit in the expression; the low bits are simply forced to zero.
    function automatic logic [XLEN-1:0] align_target(input logic [XLEN-1:0] target);
        return target & ~XLEN'(INSTR_BYTES - 1);
    endfunction

    function automatic logic [XLEN-1:0] next_seq_pc(input logic [XLEN-1:0] pc);
        return pc + XLEN'(INSTR_BYTES);
    endfunction

endpackage

// File: rtl/fetch_seq_if.sv
// Bus bundle for the fetch sequencer: instruction-memory request/response channel
// plus the downstream instruction handshake.
//
// Signals:
//   imem_req    : fetch side requests a memory read
//   imem_addr   : read address, valid while imem_req is high
//   imem_gnt    : memory accepts the request (transfer on imem_req & imem_gnt)
//   imem_rvalid : response strobe, exactly one per granted request
//   imem_rdata  : response data, valid with imem_rvalid
//   instr_valid : fetched instruction available downstream
//   instr       : fetched instruction word
//   instr_pc    : address the instruction was fetched from
//   instr_ready : downstream consumes the instruction (transfer on valid & ready)
//
// Modports: master = fetch sequencer, slave = memory plus consumer side.
interface fetch_seq_if;
    import fetch_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [ILEN-1:0] imem_rdata;
    logic            instr_valid;
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;
    logic            instr_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata,
        output instr_valid,
        output instr,
        output instr_pc,
        input  instr_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata,
        input  instr_valid,
        input  instr,
        input  instr_pc,
        output instr_ready
    );

endinterface

// File: rtl/redirect_arb.sv
// Combinational priority select between the three redirect sources.
// Priority is trap > jalr > br; only the winner's target reaches the output,
// and the selected target is forced onto an instruction boundary.
//
// Ports:
//   trap_valid, trap_target : trap redirect request and vector
//   jalr_valid, jalr_target : register-indirect jump request and target
//   br_taken,   br_target   : taken branch / JAL request and target
//   redirect_valid          : any source is requesting a redirect
//   redirect_target         : aligned target of the winning source
module redirect_arb
    import fetch_pkg::*;
(
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_target,
    input  logic            jalr_valid,
    input  logic [XLEN-1:0] jalr_target,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_target
);

    logic [XLEN-1:0] raw_target;

    always_comb begin
        redirect_valid = trap_valid | jalr_valid | br_taken;
        raw_target     = br_target;
        if (trap_valid) begin
            raw_target = trap_target;
        end else if (jalr_valid) begin
            raw_target = jalr_target;
        end
        redirect_target = align_target(raw_target);
    end

endmodule

// File: rtl/fetch_seq.sv
// Single-outstanding instruction fetch sequencer.
//
// Walks IDLE -> REQ -> WAIT -> HOLD -> REQ ..., issuing one instruction-memory
// read at a time, presenting each returned word downstream with its address,
// and following trap / jalr / branch redirects. A redirect that arrives while a
// granted read is still in flight sets the kill flag so the stale response is
// dropped when it returns.
//
// Parameters:
//   RESET_PC : first fetch address after reset
//
// Ports:
//   clk                     : clock, rising edge
//   rst                     : asynchronous active-high reset
//   trap_valid, trap_target : trap redirect (highest priority)
//   jalr_valid, jalr_target : register-indirect jump redirect
//   br_taken,   br_target   : taken branch / JAL redirect (lowest priority)
//   bus                     : memory and downstream handshakes (fetch_seq_if.master)
module fetch_seq
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               trap_valid,
    input  logic [XLEN-1:0]    trap_target,
    input  logic               jalr_valid,
    input  logic [XLEN-1:0]    jalr_target,
    input  logic               br_taken,
    input  logic [XLEN-1:0]    br_target,
    fetch_seq_if.master        bus
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            kill_q, kill_d;
    logic [ILEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] instr_pc_q, instr_pc_d;
    logic            req_q;
    logic [XLEN-1:0] addr_q;
    logic            valid_q;

    logic            redirect_valid;
    logic [XLEN-1:0] redirect_target;
    logic            granted;

    redirect_arb u_redirect_arb (
        .trap_valid      (trap_valid),
        .trap_target     (trap_target),
        .jalr_valid      (jalr_valid),
        .jalr_target     (jalr_target),
        .br_taken        (br_taken),
        .br_target       (br_target),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target)
    );

    assign granted = req_q & bus.imem_gnt;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        kill_d     = kill_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;

        unique case (state_q)
            IDLE: begin
                // A redirect here only retargets pc; the one-cycle IDLE still moves on.
                state_d = REQ;
                if (redirect_valid) begin
                    pc_d = redirect_target;
                end
            end

            REQ: begin
                if (redirect_valid) begin
                    pc_d = redirect_target;
                    if (granted) begin
                        // The read just accepted fetches the old pc; discard its data.
                        kill_d  = 1'b1;
                        state_d = WAIT;
                    end
                end else if (granted) begin
                    state_d = WAIT;
                end
            end

            WAIT: begin
                if (redirect_valid) begin
                    pc_d = redirect_target;
                    if (bus.imem_rvalid) begin
                        kill_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        kill_d = 1'b1;
                    end
                end else if (bus.imem_rvalid) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        instr_d    = bus.imem_rdata;
                        instr_pc_d = pc_q;
                        pc_d       = next_seq_pc(pc_q);
                        state_d    = HOLD;
                    end
                end
            end

            HOLD: begin
                // A redirect wins over the handshake; a coincident transfer is
                // left for the consumer to squash.
                if (redirect_valid) begin
                    pc_d    = redirect_target;
                    state_d = REQ;
                end else if (bus.instr_ready) begin
                    state_d = REQ;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            kill_q     <= 1'b0;
            instr_q    <= '0;
            instr_pc_q <= '0;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            kill_q     <= kill_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            req_q      <= (state_d == REQ);
            addr_q     <= pc_d;
            valid_q    <= (state_d == HOLD);
        end
    end

    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = addr_q;
    assign bus.instr_valid = valid_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;

endmodule

// File: doc/fetch_seq.md
FETCH_SEQ -- requirements
Module: fetch_seq

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk  in  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports trap_valid in 1 / trap_target in 32: trap redirect request and vector.
REQ-005 SHALL have ports jalr_valid in 1 / jalr_target in 32: register-indirect jump redirect and target.
REQ-006 SHALL have ports br_taken in 1 / br_target in 32: taken branch or JAL redirect and target (PC+Imm).
REQ-007 SHALL have ports imem_req out 1, imem_addr out 32, imem_gnt in 1: instruction-memory request, accepted on req&gnt.
REQ-008 SHALL have ports imem_rvalid in 1 / imem_rdata in 32: memory response, one per granted request, ≥1 cycle after grant.
REQ-009 SHALL have ports instr_valid out 1, instr out 32, instr_pc out 32, instr_ready in 1: downstream handshake, transfer on valid&ready.

Function
REQ-010 SHALL hold a 32-bit pc register and a kill flag, and implement FSM states IDLE, REQ, WAIT, HOLD.
REQ-011 SHALL go IDLE->REQ unconditionally one cycle after reset release.
REQ-012 SHALL in REQ drive imem_req=1, imem_addr=pc; on imem_gnt go WAIT; otherwise stay REQ, with imem_addr allowed to change while ungranted.
REQ-013 SHALL in WAIT, on imem_rvalid with kill=0 and no redirect: capture instr=imem_rdata, instr_pc=pc, pc<=pc+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0), go HOLD.
REQ-014 SHALL in HOLD drive instr_valid=1 with instr/instr_pc stable; on instr_ready go REQ; otherwise stay HOLD.
REQ-015 SHALL keep instr_valid=0 in IDLE, REQ and WAIT; throughput is one instruction per 3 cycles with zero-wait memory and ready downstream.
REQ-016 SHALL resolve simultaneous redirects by priority trap > jalr > br; only the winning target is used.
REQ-017 SHALL force bits [1:0] of any selected redirect target to 0.
REQ-018 SHALL on redirect in IDLE: pc<=target, state unchanged.
REQ-019 SHALL on redirect in REQ without gnt: pc<=target, stay REQ; with gnt in the same cycle: pc<=target, kill<=1, go WAIT.
REQ-020 SHALL on redirect in WAIT without rvalid: pc<=target, kill<=1, stay WAIT; with rvalid (any kill): drop response, pc<=target, kill<=0, go REQ.
REQ-021 SHALL in WAIT on rvalid with kill=1 and no redirect: drop response, kill<=0, pc unchanged, go REQ.
REQ-022 SHALL on redirect in HOLD: pc<=target, go REQ, instr_valid=0 next cycle; if instr_ready is also high that cycle, the transfer counts and the consumer squashes it.
REQ-023 SHALL ignore imem_rvalid in IDLE, REQ and HOLD.
REQ-024 SHALL never have more than one granted, unreturned memory request.

Reset
REQ-025 SHALL on rst asynchronously set state=IDLE, pc=RESET_PC, kill=0, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0.
REQ-026 SHALL on rst mid-transaction abandon any outstanding request; its late response falls under REQ-023 or is absorbed by the IDLE cycle.

Structure
REQ-027 SHALL take from shared package fetch_pkg: fetch_state_t enum (IDLE, REQ, WAIT, HOLD), XLEN=32, ILEN=32, INSTR_BYTES=4.
REQ-028 SHALL contain one sub-module redirect_arb: purely combinational priority select of trap/jalr/br producing redirect_valid and the aligned target.

Verification
REQ-029 SHALL cover: reset with RESET_PC=0x100, zero-wait memory, ready=1 -> imem_addr 0x100, 0x104, 0x108 every 3 cycles; instr_pc matches.
REQ-030 SHALL cover: trap_valid(0x80) + jalr_valid(0x200) + br_taken(0x300) in one REQ cycle -> next imem_addr=0x80.
REQ-031 SHALL cover: br_taken(0x40) in WAIT before rvalid, rdata=0xDEADBEEF -> response dropped, instr_valid stays 0, next request at 0x40.
REQ-032 SHALL cover: instr_ready=0 for 5 cycles in HOLD -> instr and instr_pc stable, no imem_req until ready.
REQ-033 SHALL cover: pc=0xFFFF_FFFC fetch, then jalr_target=0x1003 -> next fetch 0x0, then a later redirect fetches 0x1000.
REQ-034 SHALL cover: rst asserted in WAIT, rvalid during IDLE -> no instr_valid, first fetch at RESET_PC.
